// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC sequencer: FSM state encoding,
// ROM address widths, ROM read latency and the address bundle handed from
// the address generator to the sequencer top.
package conv_pkg;

    localparam int unsigned WEIGHT_AW   = 7;
    localparam int unsigned DATA_AW     = 15;
    localparam int unsigned BIAS_AW     = 7;
    localparam int unsigned ROM_LATENCY = 1;

    // Counter widths sized for the largest legal KERNEL_LEN / NUM_POS / NUM_CH.
    localparam int unsigned TAP_W   = 7;
    localparam int unsigned POS_W   = 10;
    localparam int unsigned CH_W    = 4;

    // Drain covers the ROM read latency plus the MAC output register.
    localparam int unsigned DRAIN_LEN = ROM_LATENCY + 1;
    localparam int unsigned DRAIN_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_BIAS  = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } conv_state_e;

    typedef struct packed {
        logic [WEIGHT_AW-1:0] weight;
        logic [DATA_AW-1:0]   data;
        logic [BIAS_AW-1:0]   bias;
    } conv_addr_t;

endpackage

// File: rtl/conv_addr_gen.sv
// Tap / position / channel counters and ROM address accumulators.
// Addresses are built by running adds only:
//   weight = ch*KERNEL_LEN + tap, data = pos*DATA_STEP + tap, bias = ch.
// Optional feature macro: CONV_SEQ_BIAS_EN (bias address driven from ch;
// otherwise the bias address is held at 0).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   tap_step        advance one tap (sequencer is in MAC)
//   res_adv         result transferred: advance pos/ch and reload addresses
//   addr            registered weight/data/bias ROM addresses
//   tap_first_c     tap counter at 0
//   tap_last_c      tap counter at KERNEL_LEN-1
//   first_c         current result is ch=0,pos=0
//   last_c          current result is ch=NUM_CH-1,pos=NUM_POS-1
module conv_addr_gen
    import conv_pkg::*;
#(
    parameter int unsigned KERNEL_LEN = 9,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned NUM_POS    = 16,
    parameter int unsigned DATA_STEP  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tap_step,
    input  logic       res_adv,
    output conv_addr_t addr,
    output logic       tap_first_c,
    output logic       tap_last_c,
    output logic       first_c,
    output logic       last_c
);

    localparam logic [WEIGHT_AW-1:0] W_INC = WEIGHT_AW'(KERNEL_LEN);
    localparam logic [DATA_AW-1:0]   D_INC = DATA_AW'(DATA_STEP);

    logic [TAP_W-1:0]     tap_q;
    logic [POS_W-1:0]     pos_q;
    logic [CH_W-1:0]      ch_q;
    logic [WEIGHT_AW-1:0] w_base_q;
    logic [DATA_AW-1:0]   d_base_q;
    logic [WEIGHT_AW-1:0] w_addr_q;
    logic [DATA_AW-1:0]   d_addr_q;
    logic                 pos_last;
    logic                 ch_last;

    assign pos_last    = (pos_q == POS_W'(NUM_POS - 1));
    assign ch_last     = (ch_q == CH_W'(NUM_CH - 1));
    assign tap_first_c = (tap_q == '0);
    assign tap_last_c  = (tap_q == TAP_W'(KERNEL_LEN - 1));
    assign first_c     = (pos_q == '0) && (ch_q == '0);
    assign last_c      = pos_last && ch_last;

    // Counters and accumulators; w_base/d_base hold ch*K and pos*STEP.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_q    <= '0;
            pos_q    <= '0;
            ch_q     <= '0;
            w_base_q <= '0;
            d_base_q <= '0;
            w_addr_q <= '0;
            d_addr_q <= '0;
        end else if (res_adv) begin
            tap_q <= '0;
            if (pos_last) begin
                pos_q    <= '0;
                d_base_q <= '0;
                d_addr_q <= '0;
                if (ch_last) begin
                    ch_q     <= '0;
                    w_base_q <= '0;
                    w_addr_q <= '0;
                end else begin
                    ch_q     <= ch_q + CH_W'(1);
                    w_base_q <= w_base_q + W_INC;
                    w_addr_q <= w_base_q + W_INC;
                end
            end else begin
                pos_q    <= pos_q + POS_W'(1);
                d_base_q <= d_base_q + D_INC;
                d_addr_q <= d_base_q + D_INC;
                // Same channel: rewind the weight address to its first tap.
                w_addr_q <= w_base_q;
            end
        end else if (tap_step) begin
            if (tap_last_c) begin
                // Addresses hold at the final tap until the result transfers.
                tap_q <= '0;
            end else begin
                tap_q    <= tap_q + TAP_W'(1);
                w_addr_q <= w_addr_q + WEIGHT_AW'(1);
                d_addr_q <= d_addr_q + DATA_AW'(1);
            end
        end
    end

    assign addr.weight = w_addr_q;
    assign addr.data   = d_addr_q;
`ifdef CONV_SEQ_BIAS_EN
    assign addr.bias   = BIAS_AW'(ch_q);
`else
    assign addr.bias   = '0;
`endif

endmodule

// File: rtl/conv_mac_sequencer.sv
// Convolution MAC sequencer: walks every (channel, position) result of a
// frame, issuing bias/weight/data ROM reads and MAC strobes, then hands each
// result downstream with a valid/ready transfer.
// Optional feature macro: CONV_SEQ_BIAS_EN. Defined: each result starts with
// a 1-cycle BIAS read and mac_clear means load-bias. Undefined: BIAS is
// skipped, bias_en/bias_addr stay 0 and mac_clear means load-zero.
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   start                       1-cycle pulse, starts a frame from IDLE
//   out_ready                   downstream accepts the current result
//   weight_en/weight_addr       weight ROM read
//   datain_en/data_addr         input-data ROM read
//   bias_en/bias_addr           bias ROM read
//   mac_en/mac_clear/mac_last   MAC accumulate, first-tap load, final tap
//   out_valid/out_start/out_end result valid, first / last result of frame
//   busy/done                   frame in progress, 1-cycle frame complete
module conv_mac_sequencer
    import conv_pkg::*;
#(
    parameter int unsigned KERNEL_LEN = 9,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned NUM_POS    = 16,
    parameter int unsigned DATA_STEP  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 out_ready,
    output logic                 weight_en,
    output logic [WEIGHT_AW-1:0] weight_addr,
    output logic                 datain_en,
    output logic [DATA_AW-1:0]   data_addr,
    output logic                 bias_en,
    output logic [BIAS_AW-1:0]   bias_addr,
    output logic                 mac_en,
    output logic                 mac_clear,
    output logic                 mac_last,
    output logic                 out_valid,
    output logic                 out_start,
    output logic                 out_end,
    output logic                 busy,
    output logic                 done
);

`ifdef CONV_SEQ_BIAS_EN
    localparam conv_state_e RES_FIRST = ST_BIAS;
`else
    localparam conv_state_e RES_FIRST = ST_MAC;
`endif

    conv_state_e        state_q;
    conv_state_e        state_nxt;
    logic [DRAIN_W-1:0] drain_q;
    conv_addr_t         addr;
    logic               tap_step;
    logic               res_adv;
    logic               tap_first_c;
    logic               tap_last_c;
    logic               first_c;
    logic               last_c;

    assign tap_step = (state_q == ST_MAC);
    assign res_adv  = (state_q == ST_OUT) && out_ready;

    conv_addr_gen #(
        .KERNEL_LEN (KERNEL_LEN),
        .NUM_CH     (NUM_CH),
        .NUM_POS    (NUM_POS),
        .DATA_STEP  (DATA_STEP)
    ) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .tap_step    (tap_step),
        .res_adv     (res_adv),
        .addr        (addr),
        .tap_first_c (tap_first_c),
        .tap_last_c  (tap_last_c),
        .first_c     (first_c),
        .last_c      (last_c)
    );

    assign weight_addr = addr.weight;
    assign data_addr   = addr.data;
    assign bias_addr   = addr.bias;

    // Next-state decode; start only matters in IDLE.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_nxt = RES_FIRST;
            ST_BIAS:  state_nxt = ST_MAC;
            ST_MAC:   if (tap_last_c) state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_q == DRAIN_W'(DRAIN_LEN - 1)) state_nxt = ST_OUT;
            ST_OUT:   if (out_ready) state_nxt = last_c ? ST_DONE : RES_FIRST;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register; state-aligned outputs are decoded from the next state
    // so they are registered yet coincide with the state they describe.
    // MAC strobes come from the current state: one ROM-latency cycle late.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            drain_q   <= '0;
            weight_en <= 1'b0;
            datain_en <= 1'b0;
            mac_en    <= 1'b0;
            mac_clear <= 1'b0;
            mac_last  <= 1'b0;
            out_valid <= 1'b0;
            out_start <= 1'b0;
            out_end   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            drain_q   <= (state_q == ST_DRAIN) ? drain_q + DRAIN_W'(1) : '0;
            weight_en <= (state_nxt == ST_MAC);
            datain_en <= (state_nxt == ST_MAC);
            mac_en    <= (state_q == ST_MAC);
            mac_clear <= (state_q == ST_MAC) && tap_first_c;
            mac_last  <= (state_q == ST_MAC) && tap_last_c;
            out_valid <= (state_nxt == ST_OUT);
            out_start <= (state_nxt == ST_OUT) && first_c;
            out_end   <= (state_nxt == ST_OUT) && last_c;
            busy      <= (state_nxt != ST_IDLE);
            done      <= (state_nxt == ST_DONE);
        end
    end

`ifdef CONV_SEQ_BIAS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bias_en <= 1'b0;
        end else begin
            bias_en <= (state_nxt == ST_BIAS);
        end
    end
`else
    assign bias_en = 1'b0;
`endif

endmodule

// File: tb/tb_conv_mac_sequencer.sv
// Scoreboard bench for conv_mac_sequencer: stimulus queues the expected
// description of every result; a negedge monitor rebuilds each result from
// the DUT strobes and compares it when the result transfers.
`timescale 1ns/1ps
module tb_conv_mac_sequencer;

    localparam int K    = 9;
    localparam int NCH  = 4;
    localparam int NPOS = 16;
    localparam int NRES = NCH * NPOS;
`ifdef CONV_SEQ_BIAS_EN
    localparam int RES_CYC  = K + 4;
    localparam bit HAS_BIAS = 1'b1;
`else
    localparam int RES_CYC  = K + 3;
    localparam bit HAS_BIAS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, out_ready;
    logic        weight_en, datain_en, bias_en, mac_en, mac_clear, mac_last;
    logic        out_valid, out_start, out_end, busy, done;
    logic [6:0]  weight_addr, bias_addr;
    logic [14:0] data_addr;
    logic [39:0] all_out;

    logic        start1, ready1;
    logic        weight_en1, datain_en1, bias_en1, mac_en1, mac_clear1, mac_last1;
    logic        out_valid1, out_start1, out_end1, busy1, done1;
    logic [6:0]  weight_addr1, bias_addr1;
    logic [14:0] data_addr1;

    assign all_out = {weight_en, weight_addr, datain_en, data_addr, bias_en, bias_addr,
                      mac_en, mac_clear, mac_last, out_valid, out_start, out_end, busy, done};

    conv_mac_sequencer #(.KERNEL_LEN(K), .NUM_CH(NCH), .NUM_POS(NPOS), .DATA_STEP(1)) dut (
        .clk(clk), .rst(rst), .start(start), .out_ready(out_ready),
        .weight_en(weight_en), .weight_addr(weight_addr),
        .datain_en(datain_en), .data_addr(data_addr),
        .bias_en(bias_en), .bias_addr(bias_addr),
        .mac_en(mac_en), .mac_clear(mac_clear), .mac_last(mac_last),
        .out_valid(out_valid), .out_start(out_start), .out_end(out_end),
        .busy(busy), .done(done)
    );

    conv_mac_sequencer #(.KERNEL_LEN(1), .NUM_CH(1), .NUM_POS(1), .DATA_STEP(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .out_ready(ready1),
        .weight_en(weight_en1), .weight_addr(weight_addr1),
        .datain_en(datain_en1), .data_addr(data_addr1),
        .bias_en(bias_en1), .bias_addr(bias_addr1),
        .mac_en(mac_en1), .mac_clear(mac_clear1), .mac_last(mac_last1),
        .out_valid(out_valid1), .out_start(out_start1), .out_end(out_end1),
        .busy(busy1), .done(done1)
    );

    typedef struct {
        bit s;
        bit e;
        int w0;
        int d0;
        int bias;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_xfer  = 0;
    int   n_done  = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    // ---------------- monitor ----------------
    int         taps, w0, d0, addr_bad, macs, clr_idx, last_idx, bias_seen, bias_addr_seen, cyc;
    bit         in_stall, done_exp;
    logic [6:0] frz_w;
    logic [14:0] frz_d;
    exp_t       me;

    task automatic clear_acc();
        taps = 0; w0 = 0; d0 = 0; addr_bad = 0; macs = 0; clr_idx = -1; last_idx = -1;
        bias_seen = 0; bias_addr_seen = 0; cyc = 0; in_stall = 1'b0;
    endtask

    initial begin
        clear_acc();
        done_exp = 1'b0;
    end

    always @(negedge clk) begin
        if (rst) begin
            clear_acc();
            done_exp = 1'b0;
        end else begin
            if (done_exp) begin
                check("done_after_last_transfer", done, 1);
                done_exp = 1'b0;
            end
            if (done) n_done++;
            if (busy && !done) cyc++;
            if (bias_en) begin
                bias_seen++;
                bias_addr_seen = bias_addr;
            end
            if (weight_en) begin
                if (taps == 0) begin
                    w0 = weight_addr;
                    d0 = data_addr;
                end else if (weight_addr != 7'(w0 + taps) || data_addr != 15'(d0 + taps)) begin
                    addr_bad++;
                end
                if (!datain_en) addr_bad++;
                taps++;
            end
            if (mac_en) begin
                if (mac_clear) clr_idx = macs;
                if (mac_last) last_idx = macs;
                macs++;
            end
            if (out_valid && !out_ready) begin
                check("stall_enables", {weight_en, datain_en, bias_en, mac_en}, 0);
                if (in_stall) begin
                    check("stall_addr_frozen", {weight_addr, data_addr}, {frz_w, frz_d});
                end else begin
                    frz_w = weight_addr;
                    frz_d = data_addr;
                    in_stall = 1'b1;
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_result: transfer %0d with empty queue", n_xfer);
                end else begin
                    me = exp_q.pop_front();
                    check($sformatf("r%0d_out_start", n_xfer), out_start, me.s);
                    check($sformatf("r%0d_out_end", n_xfer), out_end, me.e);
                    check($sformatf("r%0d_w_first", n_xfer), w0, me.w0);
                    check($sformatf("r%0d_d_first", n_xfer), d0, me.d0);
                    check($sformatf("r%0d_taps", n_xfer), taps, K);
                    check($sformatf("r%0d_addr_seq_err", n_xfer), addr_bad, 0);
                    check($sformatf("r%0d_mac_count", n_xfer), macs, K);
                    check($sformatf("r%0d_mac_clear_idx", n_xfer), clr_idx, 0);
                    check($sformatf("r%0d_mac_last_idx", n_xfer), last_idx, K - 1);
                    check($sformatf("r%0d_bias_reads", n_xfer), bias_seen, HAS_BIAS ? 1 : 0);
                    check($sformatf("r%0d_bias_addr", n_xfer), bias_addr_seen, me.bias);
                    check($sformatf("r%0d_cycles", n_xfer), cyc, me.cyc);
                end
                n_xfer++;
                if (out_end) done_exp = 1'b1;
                clear_acc();
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Expected result list: ch = r/NPOS, pos = r%NPOS, weight base ch*K.
    task automatic push_frame(input int nres, input int stall0);
        exp_t e;
        for (int r = 0; r < nres; r++) begin
            e.s    = (r == 0);
            e.e    = (r == NRES - 1);
            e.w0   = ((r / NPOS) * K) % 128;
            e.d0   = r % NPOS;
            e.bias = HAS_BIAS ? (r / NPOS) : 0;
            e.cyc  = RES_CYC + ((r == 0) ? stall0 : 0);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_xfers(input int n, input string name);
        int c = 0;
        while (n_xfer < n && c < 3000) begin
            tick();
            c++;
        end
        check(name, n_xfer, n);
    endtask

    initial begin
        int c;
        rst = 1'b1; start = 1'b0; out_ready = 1'b1; start1 = 1'b0; ready1 = 1'b1;
        repeat (3) tick();
        check("reset_state", all_out, 0);

        // Reset has priority over start.
        start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_over_start_busy", busy, 0);
        tick();

        // Frame 1: full frame, ready high, stray start mid-frame.
        push_frame(NRES, 0);
        pulse_start();
        wait_xfers(5, "f1_wait_5");
        pulse_start();
        wait_xfers(NRES, "f1_all_results");
        c = 0;
        while (n_done < 1 && c < 20) begin tick(); c++; end
        tick();
        check("f1_idle_after_done", busy, 0);

        // Frame 2: 5-cycle stall on result 0, reset in MAC at tap 4 of result 10.
        out_ready = 1'b0;
        push_frame(10, 5);
        pulse_start();
        c = 0;
        while (!out_valid && c < 100) begin tick(); c++; end
        repeat (5) tick();
        out_ready = 1'b1;
        wait_xfers(NRES + 10, "f2_ten_results");
        c = 0;
        while (!(weight_en && weight_addr == 7'd4 && data_addr == 15'd14) && c < 100) begin
            tick();
            c++;
        end
        check("f2_reached_tap4_r10", data_addr, 14);
        rst = 1'b1;
        tick();
        check("reset_mid_frame_outputs", all_out, 0);
        rst = 1'b0;
        check("f2_queue_drained", exp_q.size(), 0);
        tick();

        // Frame 3: restart from ch=0,pos=0; start during DONE is dropped.
        push_frame(NRES, 0);
        pulse_start();
        c = 0;
        while (!done && c < 3000) begin tick(); c++; end
        check("f3_done_seen", done, 1);
        pulse_start();
        check("start_in_done_dropped", busy, 0);
        tick();
        check("still_idle", busy, 0);
        check("f3_queue_drained", exp_q.size(), 0);
        check("total_transfers", n_xfer, 2 * NRES + 10);
        check("done_count", n_done, 2);

        // Single-tap, single-result configuration.
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        c = 0;
        while (!mac_en1 && c < 50) begin tick(); c++; end
        check("k1_mac_clear_and_last", {mac_clear1, mac_last1}, 3);
        c = 0;
        while (!out_valid1 && c < 50) begin tick(); c++; end
        check("k1_out_start_and_end", {out_start1, out_end1}, 3);
        c = 0;
        while (!done1 && c < 50) begin tick(); c++; end
        check("k1_done", done1, 1);
        tick();
        check("k1_idle", busy1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
